// File: rtl/fft_feeder_pkg.sv
// Shared types and helpers for the FFT frame feeder: FSM encoding, default
// config word and the last-index helper.
package fft_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_FILL   = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    // bit0=1 selects the forward transform
    localparam logic [7:0] CFG_WORD_DEF = 8'h01;

    function automatic int unsigned last_idx(input int unsigned log2_n);
        return (32'd1 << log2_n) - 32'd1;
    endfunction

endpackage

// File: rtl/fft_frame_feeder_if.sv
// AXI-Stream config and data channels between the frame feeder and the FFT core.
// FEEDER_TUSER_EN adds m_tuser carrying the sample index.
interface fft_frame_feeder_if #(
    parameter int DATA_W = 16,
`ifdef FEEDER_TUSER_EN
    parameter int LOG2_N = 7,
`endif
    parameter int CFG_W  = 8
);

    logic [CFG_W-1:0]    cfg_tdata;
    logic                cfg_tvalid;
    logic                cfg_tready;
    logic [2*DATA_W-1:0] m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic                m_tlast;
`ifdef FEEDER_TUSER_EN
    logic [LOG2_N-1:0]   m_tuser;

    modport master (
        output cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast, m_tuser,
        input  cfg_tready, m_tready
    );
    modport slave (
        input  cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast, m_tuser,
        output cfg_tready, m_tready
    );
`else
    modport master (
        output cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast,
        input  cfg_tready, m_tready
    );
    modport slave (
        input  cfg_tdata, cfg_tvalid, m_tdata, m_tvalid, m_tlast,
        output cfg_tready, m_tready
    );
`endif

endinterface

// File: rtl/fft_feeder_ram.sv
// Simple dual-port frame buffer, depth 2**LOG2_N, 1-cycle synchronous read.
// The read register holds its value while re is low.
module fft_feeder_ram #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LOG2_N-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [LOG2_N-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**LOG2_N];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers one frame of ADC samples and streams it to the FFT core with imag=0.
// Build option FEEDER_TUSER_EN adds m_tuser (sample index) on the data channel.
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                LOG2_N   = 7,
    parameter int                CFG_W    = 8,
    parameter logic [CFG_W-1:0]  CFG_WORD = CFG_W'(CFG_WORD_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic                stop,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    fft_frame_feeder_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam logic [LOG2_N-1:0] LAST = LOG2_N'(last_idx(LOG2_N));

    state_e            state_q, state_d;
    logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_N-1:0] idx_q, idx_d;
    logic              rd_done_q, rd_done_d;
    logic              vld_q, vld_d;
    logic              stop_lat_q, stop_lat_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic              wr_en, rd_en, beat, last_beat;
    logic [DATA_W-1:0] rd_data;

    // The RAM read register doubles as the output register: it only advances
    // when the output slot is empty or being consumed.
    assign wr_en     = (state_q == ST_FILL) && sample_valid;
    assign rd_en     = (state_q == ST_STREAM) && !rd_done_q && (!vld_q || bus.m_tready);
    assign beat      = vld_q && bus.m_tready;
    assign last_beat = beat && (idx_q == LAST);

    fft_feeder_ram #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (sample_in),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idx_q        <= '0;
            rd_done_q    <= 1'b0;
            vld_q        <= 1'b0;
            stop_lat_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            idx_q        <= idx_d;
            rd_done_q    <= rd_done_d;
            vld_q        <= vld_d;
            stop_lat_q   <= stop_lat_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_CONFIG;
            ST_CONFIG: if (bus.cfg_tready) state_d = ST_FILL;
            ST_FILL:   if (wr_en && (wr_ptr_q == LAST)) state_d = ST_STREAM;
            ST_STREAM: begin
                if (last_beat) begin
                    state_d = (cont && !stop_lat_q && !stop) ? ST_FILL : ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_done_d    = rd_done_q;
        vld_d        = vld_q;
        idx_d        = idx_q;
        frame_done_d = last_beat;

        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_done_d = (rd_ptr_q == LAST);
            vld_d     = 1'b1;
            idx_d     = rd_ptr_q;
        end else if (beat) begin
            vld_d     = 1'b0;
        end

        if (last_beat) begin
            rd_ptr_d  = '0;
            rd_done_d = 1'b0;
            vld_d     = 1'b0;
        end

        stop_lat_d = stop_lat_q | (stop && (state_q != ST_IDLE));
        if (last_beat && (state_d == ST_IDLE)) begin
            stop_lat_d = 1'b0;
        end

        overrun_d = overrun_q;
        if ((state_q == ST_IDLE) && start) begin
            overrun_d = 1'b0;
        end else if ((state_q == ST_STREAM) && sample_valid) begin
            overrun_d = 1'b1;
        end
    end

    // Outputs are forced to zero outside their valid windows so reset leaves every output low.
    always_comb begin
        busy           = (state_q != ST_IDLE);
        bus.cfg_tvalid = (state_q == ST_CONFIG);
        bus.cfg_tdata  = bus.cfg_tvalid ? CFG_WORD : '0;
        bus.m_tvalid   = vld_q;
        bus.m_tdata    = vld_q ? {{DATA_W{1'b0}}, rd_data} : '0;
        bus.m_tlast    = vld_q && (idx_q == LAST);
`ifdef FEEDER_TUSER_EN
        bus.m_tuser    = idx_q;
`endif
        frame_done     = frame_done_q;
        overrun        = overrun_q;
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed/randomized bench for fft_frame_feeder against a transaction-level frame model.
module tb_fft_frame_feeder;

    localparam int N = 128;

    logic        clk = 1'b0;
    logic        rst, start, cont, stop, sample_valid;
    logic [15:0] sample_in;
    logic        busy, frame_done, overrun;

    fft_frame_feeder_if bus ();

    fft_frame_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont         (cont),
        .stop         (stop),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int npass = 0, nchk = 0, nfail = 0;

    // reference model: frame contents are the first N valid samples after
    // the config handshake (or after a continuing frame end)
    logic [15:0] exp_q[$];
    bit run_active, exp_cfg, collecting, in_stream, stop_seen, exp_fd, exp_ovr;
    int fill_cnt, beat_idx, stream_age;
    bit prev_vld, prev_rdy, prev_last;
    logic [31:0] prev_data;
    int beats, tlast_cnt, fd_cnt, cfg_cnt, cfg_wait;

    // stimulus knobs
    int sv_mode, rdy_mode, cfg_hold;
    bit ramp, strict;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        sample_valid = (sv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        sample_in    = (ramp && collecting) ? 16'(fill_cnt) : 16'($urandom);
        case (rdy_mode)
            0:       bus.m_tready = 1'b1;
            1:       bus.m_tready = ~bus.m_tready;
            default: bus.m_tready = 1'($urandom_range(0, 1));
        endcase
        if (cfg_hold > 0 && exp_cfg) begin
            bus.cfg_tready = 1'b0;
            cfg_hold--;
        end else begin
            bus.cfg_tready = 1'b1;
        end
    endtask

    task automatic step();
        bit fd_n, ovr_n;
        logic [15:0] s;
        chk("frame_done", frame_done, exp_fd);
        chk("overrun", overrun, exp_ovr);
        chk("busy", busy, run_active);
        chk("cfg_tvalid", bus.cfg_tvalid, exp_cfg);
        if (prev_vld && !prev_rdy) begin
            chk("hold_tvalid", bus.m_tvalid, 1);
            chk("hold_tdata", bus.m_tdata, prev_data);
            chk("hold_tlast", bus.m_tlast, prev_last);
        end
        if (!in_stream || stream_age == 0) chk("tvalid_low", bus.m_tvalid, 0);
        else if (stream_age == 1 || strict) chk("tvalid_high", bus.m_tvalid, 1);

        fd_n  = 1'b0;
        ovr_n = exp_ovr;
        if (frame_done) fd_cnt++;
        if (bus.cfg_tvalid && bus.cfg_tready) begin
            cfg_cnt++;
            chk("cfg_tdata", bus.cfg_tdata, 8'h01);
        end
        if (bus.cfg_tvalid && !bus.cfg_tready) cfg_wait++;
        if (stop && run_active) stop_seen = 1'b1;
        if (in_stream && sample_valid) ovr_n = 1'b1;
        if (in_stream) stream_age++;
        if (collecting && sample_valid) begin
            exp_q.push_back(sample_in);
            fill_cnt++;
            if (fill_cnt == N) begin
                collecting = 1'b0;
                fill_cnt   = 0;
                in_stream  = 1'b1;
                stream_age = 0;
            end
        end
        if (exp_cfg && bus.cfg_tready) begin
            exp_cfg    = 1'b0;
            collecting = 1'b1;
            fill_cnt   = 0;
        end
        if (start && !run_active) begin
            run_active = 1'b1;
            exp_cfg    = 1'b1;
            ovr_n      = 1'b0;
        end
        if (bus.m_tvalid && bus.m_tready) begin
            beats++;
            if (bus.m_tlast) tlast_cnt++;
            chk("have_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("tdata_re", bus.m_tdata[15:0], s);
            end
            chk("tdata_im", bus.m_tdata[31:16], 0);
            chk("tlast", bus.m_tlast, beat_idx == N - 1);
`ifdef FEEDER_TUSER_EN
            chk("tuser", bus.m_tuser, beat_idx);
`endif
            if (beat_idx == N - 1) begin
                fd_n      = 1'b1;
                in_stream = 1'b0;
                beat_idx  = 0;
                if (cont && !stop_seen) begin
                    collecting = 1'b1;
                    fill_cnt   = 0;
                end else begin
                    run_active = 1'b0;
                    stop_seen  = 1'b0;
                end
            end else begin
                beat_idx++;
            end
        end
        exp_fd    = fd_n;
        exp_ovr   = ovr_n;
        prev_vld  = bus.m_tvalid;
        prev_rdy  = bus.m_tready;
        prev_data = bus.m_tdata;
        prev_last = bus.m_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        drive();
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((run_active || exp_fd) && n < budget) begin
            cycle();
            n++;
        end
        chk("run_timeout", n < budget, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_active = 0; exp_cfg = 0; collecting = 0; in_stream = 0; stop_seen = 0;
        exp_fd = 0; exp_ovr = 0; prev_vld = 0; prev_rdy = 0;
        fill_cnt = 0; beat_idx = 0; stream_age = 0;
        exp_q.delete();
        chk("rst_cfg_tvalid", bus.cfg_tvalid, 0);
        chk("rst_cfg_tdata", bus.cfg_tdata, 0);
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_m_tdata", bus.m_tdata, 0);
        chk("rst_m_tlast", bus.m_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
`ifdef FEEDER_TUSER_EN
        chk("rst_m_tuser", bus.m_tuser, 0);
`endif
    endtask

    task automatic single_frame(input string tag);
        int b0 = beats, t0 = tlast_cnt, f0 = fd_cnt, c0 = cfg_cnt;
        start = 1'b1;
        cycle();
        run_until_idle(1500);
        chk({tag, "_beats"}, beats - b0, N);
        chk({tag, "_tlast"}, tlast_cnt - t0, 1);
        chk({tag, "_frame_done"}, fd_cnt - f0, 1);
        chk({tag, "_cfg"}, cfg_cnt - c0, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int n, b0, t0, f0, c0;
        start = 0; cont = 0; stop = 0; sample_valid = 0; sample_in = '0;
        bus.m_tready = 1'b1; bus.cfg_tready = 1'b1;
        sv_mode = 0; rdy_mode = 0; cfg_hold = 0; ramp = 0; strict = 0;
        beats = 0; tlast_cnt = 0; fd_cnt = 0; cfg_cnt = 0; cfg_wait = 0;
        do_reset();
        repeat (2) cycle();

        // 1: ramp, full throughput
        ramp = 1; strict = 1; sv_mode = 0; rdy_mode = 0;
        single_frame("t1");

        // 2: ready toggling
        strict = 0; rdy_mode = 1;
        single_frame("t2");

        // 3: config backpressure with random sample validity
        ramp = 0; rdy_mode = 2; sv_mode = 1; cfg_hold = 10; cfg_wait = 0;
        single_frame("t3");
        chk("t3_cfg_wait", cfg_wait, 10);

        // 4: continuous run stopped during frame 2
        sv_mode = 0; rdy_mode = 2; cont = 1;
        b0 = beats; t0 = tlast_cnt; f0 = fd_cnt; c0 = cfg_cnt;
        start = 1'b1;
        cycle();
        n = 0;
        while (tlast_cnt - t0 < 1 && n < 1500) begin cycle(); n++; end
        chk("t4_frame1_timeout", n < 1500, 1);
        repeat (20) cycle();
        stop = 1'b1;
        cycle();
        run_until_idle(1500);
        chk("t4_beats", beats - b0, 2 * N);
        chk("t4_tlast", tlast_cnt - t0, 2);
        chk("t4_frame_done", fd_cnt - f0, 2);
        chk("t4_cfg", cfg_cnt - c0, 1);
        chk("t4_busy_end", busy, 0);
        cont = 0;

        // 5: samples held valid through STREAM -> sticky overrun, cleared by start
        sv_mode = 0; rdy_mode = 0; strict = 1;
        single_frame("t5");
        chk("t5_overrun_sticky", overrun, 1);
        repeat (3) cycle();
        chk("t5_overrun_idle", overrun, 1);
        start = 1'b1;
        cycle();
        chk("t5_overrun_cleared", overrun, 0);
        run_until_idle(1500);

        // 6: reset at beat 50, then a clean frame
        strict = 0; rdy_mode = 2; sv_mode = 1;
        t0 = tlast_cnt;
        start = 1'b1;
        cycle();
        n = 0;
        while (!(in_stream && beat_idx == 50) && n < 1500) begin cycle(); n++; end
        chk("t6_reach_timeout", n < 1500, 1);
        do_reset();
        chk("t6_no_tlast", tlast_cnt - t0, 0);
        repeat (3) cycle();
        ramp = 1; sv_mode = 0; rdy_mode = 0; strict = 1;
        single_frame("t6");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
